gmux_ic_clkdiv: RTL and testbench
=================================

# gmux_ic_clkdiv

Programmable fabric clock divider and select controller that drives the internal-clock (IC) and select (IS0) inputs of the PP3 global clock mux. It derives a 50 % duty divided clock from CLK and changes the ratio only at full-period boundaries, so IC never carries a runt pulse. IS0 asserts only after IC has been stable for two full periods, and drops before IC stops, so the downstream mux falls back to the pad clock (IP) cleanly.

## Interface
- WIDTH, 8: width of the half-period divide value.
- CLK  in  1  fabric clock, rising-edge.
- RSTN  in  1  reset; one clock; reset is asynchronous and active-low.
- EN  in  1  run request; level-sensitive.
- DIV  in  WIDTH  half-period length in CLK cycles; 0 is treated as 1.
- DIV_LD  in  1  one-cycle strobe; capture DIV as the pending ratio.
- LD_DONE  out  1  one-cycle pulse when a ratio is applied.
- IC  out  1  divided clock; registered; feeds the GMUX IC input.
- IS0  out  1  registered select; 1 selects IC in the GMUX.
- BUSY  out  1  state != IDLE.

## Operation
- Registers: state, cnt[WIDTH], div_q[WIDTH], pend[WIDTH], pend_v, per[1:0] (saturating completed-period count), IC, IS0, LD_DONE.
- Reset: state=IDLE, IC=0, IS0=0, LD_DONE=0, BUSY=0, cnt=0, div_q=1, pend_v=0, per=0.
- States: IDLE, RUN, DRAIN.
- IDLE: IC=0, IS0=0.
  - DIV_LD sets pend=max(DIV,1) and pend_v=1, and pulses LD_DONE on the next cycle.
  - When EN=1 at an edge: div_q = pend_v ? pend : div_q, pend_v=0, cnt=0, per=0, IC<=1, and go to RUN.
- RUN/DRAIN divider:
  - Each edge, cnt++.
  - When cnt==div_q-1: cnt<=0 and IC toggles.
  - A low-to-high toggle is the period boundary.
- At a period boundary in RUN:
  - per saturates at 2.
  - If pend_v or DIV_LD: div_q<=(DIV_LD ? max(DIV,1) : pend), pend_v<=0, LD_DONE pulses on the same edge.
  - IS0<=1 when per reaches 2.
- DIV_LD in RUN outside a boundary: pend<=max(DIV,1), pend_v<=1. A later strobe overwrites an earlier one (last wins).
- EN=0 sampled in RUN: IS0<=0 on that edge and go to DRAIN.
- DRAIN:
  - Divider continues until the end of the current low phase.
  - At the would-be rising boundary: IC stays 0, go to IDLE, per<=0.
  - DIV_LD is still captured into pend but not applied.
- EN re-asserted during DRAIN is ignored until IDLE; a restart occurs on the edge after entry to IDLE.
- Once IS0 drops, it reasserts only after a fresh start plus two completed periods.

## Timing
- EN sampled 1 at edge 0 in IDLE: IC=1 after edge 0.
- IC falls after edge H and rises after edge 2H. Period = 2H CLK cycles, high H, low H.
- IS0 rises at edge 4H, coincident with the third IC rising edge.
- EN sampled 0 at edge k: IS0=0 after edge k. IC ends low at the next boundary; BUSY falls on that same edge.
- A ratio change takes effect on the first high phase after the boundary.
- LD_DONE:
  - In RUN: pulses on the boundary edge.
  - In IDLE: pulses one cycle after DIV_LD.
- RSTN low: all outputs 0 immediately, without waiting for CLK. Operation resumes from IDLE on the first edge after release.

## Structure
- Shared package pp3_clkdiv_pkg:
  - state enum {IDLE, RUN, DRAIN}.
  - Constant MIN_DIV=1.
  - LOCK_PERIODS=2.
- Single module, no sub-module.
- Optional helper function sat_div(DIV) in the package, returning max(DIV,1).

## Test plan
- Reset, DIV=3, EN=1 at edge 0: IC high for cycles 1-3, low for 4-6, repeating. IS0=1 after edge 12. BUSY=1 from edge 0.
- DIV=0, EN=1: IC = CLK/2 (period 2). IS0=1 after edge 4.
- DIV=2 running, DIV_LD with DIV=5 mid-high-phase: IC finishes its 2/2 period unchanged. LD_DONE pulses at the next rising boundary; IC is then 5 high, 5 low. IS0 stays 1 throughout.
- DIV=4 running, IS0=1, EN dropped at cnt=1 of high phase: IS0=0 next edge. IC completes the high phase (3 more cycles) and 4 low cycles, then holds 0. BUSY=0 at that boundary.
- EN toggled 1→0→1 within DRAIN: no restart until IDLE is reached. IC rises one cycle after IDLE entry. IS0 requires two new periods.
- RSTN asserted with IC=1, IS0=1 mid-RUN: IC, IS0, BUSY, LD_DONE all 0 immediately. pend_v is cleared. After release with EN=1, div_q=1 (CLK/2).

Source files
------------

// File: rtl/pp3_clkdiv_pkg.sv
// pp3_clkdiv_pkg
// Shared definitions for the PP3 global-clock-mux fabric divider:
//   state_e      : controller states (IDLE, RUN, DRAIN)
//   MIN_DIV      : smallest legal half-period; a DIV of 0 is raised to this
//   LOCK_PERIODS : completed IC periods required before IS0 may assert
package pp3_clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int MIN_DIV      = 1;
  localparam int LOCK_PERIODS = 2;

endpackage

// File: rtl/gmux_ic_clkdiv.sv
// gmux_ic_clkdiv
// Generates the IC (internal clock) and IS0 (select) inputs of the PP3 global
// clock mux. IC is a 50 % duty clock of period 2*div CLK cycles; ratio
// changes are applied only at the low-to-high boundary so IC never carries a
// runt pulse. IS0 asserts once IC has completed LOCK_PERIODS full periods and
// drops before IC stops, so the mux can fall back to the pad clock cleanly.
//
// Ports:
//   CLK     in   fabric clock, rising edge
//   RSTN    in   asynchronous active-low reset
//   EN      in   run request (level)
//   DIV     in   half-period length in CLK cycles (0 is treated as 1)
//   DIV_LD  in   one-cycle strobe capturing DIV as the pending ratio
//   LD_DONE out  one-cycle pulse when a ratio is accepted/applied
//   IC      out  registered divided clock
//   IS0     out  registered select (1 selects IC)
//   BUSY    out  controller not idle
module gmux_ic_clkdiv
  import pp3_clkdiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             DIV_LD,
  output logic             LD_DONE,
  output logic             IC,
  output logic             IS0,
  output logic             BUSY
);

  function automatic logic [WIDTH-1:0] sat_div(input logic [WIDTH-1:0] v);
    return (v < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : v;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [1:0]       per_q, per_d;
  logic             ic_q, ic_d;
  logic             is0_q, is0_d;
  logic             ld_done_q, ld_done_d;

  logic [WIDTH-1:0] div_ld_val;
  logic             terminal;

  assign div_ld_val = sat_div(DIV);
  // div_q is never below 1, so div_q-1 cannot wrap.
  assign terminal   = (cnt_q == (div_q - WIDTH'(1)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    per_d     = per_q;
    ic_d      = ic_q;
    is0_d     = is0_q;
    ld_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        ic_d  = 1'b0;
        is0_d = 1'b0;
        if (DIV_LD) begin
          pend_d    = div_ld_val;
          pend_v_d  = 1'b1;
          ld_done_d = 1'b1;
        end
        if (EN) begin
          // A strobe on the start edge itself wins over an older pending value.
          div_d    = DIV_LD ? div_ld_val : (pend_v_q ? pend_q : div_q);
          pend_v_d = 1'b0;
          cnt_d    = '0;
          per_d    = '0;
          ic_d     = 1'b1;
          state_d  = RUN;
        end
      end

      RUN: begin
        if (DIV_LD) begin
          pend_d   = div_ld_val;
          pend_v_d = 1'b1;
        end
        if (terminal) begin
          cnt_d = '0;
          ic_d  = ~ic_q;
          if (!ic_q) begin
            // Rising boundary: count the completed period and swap ratio here
            // so the new value starts with a full high phase.
            if (per_q != 2'(LOCK_PERIODS)) per_d = per_q + 2'd1;
            if (per_d == 2'(LOCK_PERIODS)) is0_d = 1'b1;
            if (DIV_LD || pend_v_q) begin
              div_d     = DIV_LD ? div_ld_val : pend_q;
              pend_v_d  = 1'b0;
              ld_done_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
        // Deselect first; IC is allowed to run out its current period.
        if (!EN) begin
          is0_d   = 1'b0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (DIV_LD) begin
          pend_d   = div_ld_val;
          pend_v_d = 1'b1;
        end
        if (terminal) begin
          cnt_d = '0;
          ic_d  = 1'b0;
          if (!ic_q) begin
            // Suppressed rising edge: IC parks low.
            per_d   = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
        ic_d    = 1'b0;
        is0_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= WIDTH'(MIN_DIV);
      pend_v_q  <= 1'b0;
      per_q     <= '0;
      ic_q      <= 1'b0;
      is0_q     <= 1'b0;
      ld_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_v_q  <= pend_v_d;
      per_q     <= per_d;
      ic_q      <= ic_d;
      is0_q     <= is0_d;
      ld_done_q <= ld_done_d;
    end
  end

  // Pending ratio is qualified by pend_v_q, so it needs no reset.
  always_ff @(posedge CLK) begin
    pend_q <= pend_d;
  end

  assign LD_DONE = ld_done_q;
  assign IC      = ic_q;
  assign IS0     = is0_q;
  assign BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_gmux_ic_clkdiv.sv
module tb_gmux_ic_clkdiv;

  logic       CLK;
  logic       RSTN;
  logic       EN;
  logic [7:0] DIV;
  logic       DIV_LD;
  logic       LD_DONE;
  logic       IC;
  logic       IS0;
  logic       BUSY;

  int n_asserts = 0;
  int n_fail    = 0;

  gmux_ic_clkdiv #(.WIDTH(8)) dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .EN     (EN),
    .DIV    (DIV),
    .DIV_LD (DIV_LD),
    .LD_DONE(LD_DONE),
    .IC     (IC),
    .IS0    (IS0),
    .BUSY   (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cyc,
                         input logic ic_e, input logic is0_e,
                         input logic busy_e, input logic ld_e);
    chk({tag, "_ic"},   cyc, IC,      ic_e);
    chk({tag, "_is0"},  cyc, IS0,     is0_e);
    chk({tag, "_busy"}, cyc, BUSY,    busy_e);
    chk({tag, "_ld"},   cyc, LD_DONE, ld_e);
  endtask

  initial begin
    RSTN   = 1'b1;
    EN     = 1'b0;
    DIV    = 8'd0;
    DIV_LD = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #2 RSTN = 1'b0;
    #1 chk_all("rst_async", -1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk_all("rst_hold", -1, 1'b0, 1'b0, 1'b0, 1'b0);
    RSTN = 1'b1;
    tick();
    chk_all("idle", -1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load DIV=3 in IDLE: LD_DONE one cycle later, single pulse.
    DIV = 8'd3; DIV_LD = 1'b1;
    tick();
    chk_all("ld3_idle", -1, 1'b0, 1'b0, 1'b0, 1'b1);
    DIV_LD = 1'b0; DIV = 8'd9;
    tick();
    chk_all("ld3_idle_end", -1, 1'b0, 1'b0, 1'b0, 1'b0);

    // H=3 run, EN dropped at cnt=1 of the high phase after edge 13.
    for (int e = 0; e <= 18; e++) begin
      EN = (e < 14);
      tick();
      chk_all("h3", e,
              (e inside {[0:2], [6:8], [12:14]}),
              (e inside {[12:13]}),
              (e < 18),
              1'b0);
    end

    // DIV=0 loaded in IDLE (saturates to 1).
    EN = 1'b0; DIV = 8'd0; DIV_LD = 1'b1;
    tick();
    chk_all("ld0_idle", -1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Continuous run: CLK/2, ratio changes 2 -> 5 -> 4, drain with EN
    // toggling, restart with fresh lock, then a pending load before reset.
    for (int e = 0; e <= 60; e++) begin
      EN     = !(e inside {36, 37, 38, 40});
      DIV_LD = (e inside {6, 11, 25, 60});
      case (e)
        6:       DIV = 8'd2;
        11:      DIV = 8'd5;
        25:      DIV = 8'd4;
        60:      DIV = 8'd6;
        default: DIV = 8'd7;
      endcase
      tick();
      chk_all("run", e,
              (e inside {0, 2, 4, [6:7], [10:11], [14:18], [24:28], [34:37],
                         [43:46], [51:54], [59:60]}),
              (e inside {[4:35], [59:60]}),
              (e != 42),
              (e inside {6, 14, 34}));
    end
    DIV_LD = 1'b0;
    DIV    = 8'd7;

    // Reset mid-RUN with IC=1, IS0=1 and a pending ratio of 6.
    #2 RSTN = 1'b0;
    #1 chk_all("rst_run", -1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("rst_run_hold", -1, 1'b0, 1'b0, 1'b0, 1'b0);
    RSTN = 1'b1;
    EN   = 1'b1;

    // Pending value must be gone: restart runs at div=1.
    for (int f = 0; f <= 5; f++) begin
      tick();
      chk_all("post_rst", f, (f % 2 == 0), (f >= 4), 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
